// File: rtl/riscv_pkg.sv
// Shared definitions for the arithmetic pipeline.
//   NUM_ARITH_CORE : number of arithmetic issue lanes
//   AL_SIZE / AL_W : active-list depth and address width
//   PREG_IDX_W     : physical register index width
//   al_in_window() : circular membership test for the surviving
//                    active-list window [back, new_front)
package riscv_pkg;

  localparam int NUM_ARITH_CORE = 2;
  localparam int AL_SIZE        = 32;
  localparam int AL_W           = $clog2(AL_SIZE);
  localparam int PREG_IDX_W     = 6;

  typedef logic [PREG_IDX_W-1:0] preg_t;
  typedef logic [AL_W-1:0]       al_addr_t;

  // AL_SIZE is a power of two, so the AL_W-bit subtractions wrap
  // modulo AL_SIZE on their own. An empty window (new_front == back)
  // gives span 0, and no address is then in the window.
  function automatic logic al_in_window(input al_addr_t addr,
                                        input al_addr_t back,
                                        input al_addr_t new_front);
    al_addr_t offset;
    al_addr_t span;
    offset = addr - back;
    span   = new_front - back;
    return offset < span;
  endfunction

endpackage

// File: rtl/operand_bypass_mux.sv
// Priority bypass select for one source operand.
//   rs       : physical register being read
//   rf_data  : register-file read data for rs
//   wb_valid : per-port writeback valid
//   wb_rd    : per-port writeback destination
//   wb_data  : per-port writeback value
//   data     : value from the lowest-numbered matching writeback
//              port, else the register-file data
module operand_bypass_mux #(
  parameter int NUM_WB = 2,
  parameter int PREG_W = 6,
  parameter int XLEN   = 32
) (
  input  logic [PREG_W-1:0] rs,
  input  logic [XLEN-1:0]   rf_data,
  input  logic              wb_valid [NUM_WB],
  input  logic [PREG_W-1:0] wb_rd    [NUM_WB],
  input  logic [XLEN-1:0]   wb_data  [NUM_WB],
  output logic [XLEN-1:0]   data
);

  // NOTE: the default assignment comes first so every path through the
  // block writes data and no latch is inferred. Blocking assignments
  // let later loop iterations override earlier ones within this block.
  // Scanning from the highest port down makes the lowest port win.
  always_comb begin
    data = rf_data;
    for (int k = NUM_WB - 1; k >= 0; k--) begin
      if (wb_valid[k] && (wb_rd[k] == rs)) begin
        data = wb_data[k];
      end
    end
  end

endmodule

// File: rtl/arith_operand_fetch.sv
// Register-read stage behind the arithmetic issue queue.
// Per lane: drives PRF read addresses from rs1/rs2, resolves operands
// through the writeback bypass, and registers the resolved micro-op in
// a one-deep slot that feeds the ALU.
//   clk, reset        : clock, asynchronous active-high reset
//   stall_in          : hold all slots, ignore incoming ops
//   i_*               : issued micro-op per lane
//   prf_raddr/rdata   : PRF read port (lane L: 2L = rs1, 2L+1 = rs2)
//   wb_*              : writeback bypass ports
//   if_recall, new_front, back : flush slots outside [back, new_front)
//   o_*               : registered slot contents per lane
//   busy              : any slot valid
module arith_operand_fetch
  import riscv_pkg::*;
#(
  parameter int NUM_LANES = NUM_ARITH_CORE,
  parameter int PREG_W    = PREG_IDX_W,
  parameter int XLEN      = 32,
  parameter int CTL_W     = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall_in,
  input  logic              i_valid    [NUM_LANES],
  input  logic [PREG_W-1:0] i_rs1      [NUM_LANES],
  input  logic [PREG_W-1:0] i_rs2      [NUM_LANES],
  input  logic [PREG_W-1:0] i_rd       [NUM_LANES],
  input  logic              i_uses_rs1 [NUM_LANES],
  input  logic              i_uses_rs2 [NUM_LANES],
  input  logic              i_uses_imm [NUM_LANES],
  input  logic              i_uses_rd  [NUM_LANES],
  input  logic [XLEN-1:0]   i_imm      [NUM_LANES],
  input  logic [AL_W-1:0]   i_al_addr  [NUM_LANES],
  input  logic [CTL_W-1:0]  i_ctl      [NUM_LANES],
  output logic [PREG_W-1:0] prf_raddr  [2*NUM_LANES],
  input  logic [XLEN-1:0]   prf_rdata  [2*NUM_LANES],
  input  logic              wb_valid   [NUM_LANES],
  input  logic [PREG_W-1:0] wb_rd      [NUM_LANES],
  input  logic [XLEN-1:0]   wb_data    [NUM_LANES],
  input  logic              if_recall,
  input  logic [AL_W-1:0]   new_front,
  input  logic [AL_W-1:0]   back,
  output logic              o_valid    [NUM_LANES],
  output logic [XLEN-1:0]   o_op_a     [NUM_LANES],
  output logic [XLEN-1:0]   o_op_b     [NUM_LANES],
  output logic [PREG_W-1:0] o_rd       [NUM_LANES],
  output logic              o_uses_rd  [NUM_LANES],
  output logic [AL_W-1:0]   o_al_addr  [NUM_LANES],
  output logic [CTL_W-1:0]  o_ctl      [NUM_LANES],
  output logic              busy
);

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    logic [XLEN-1:0] src1;
    logic [XLEN-1:0] src2;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            keep_new;
    logic            keep_held;

    // Addresses follow rs1/rs2 unconditionally; validity is applied at capture.
    assign prf_raddr[2*l]   = i_rs1[l];
    assign prf_raddr[2*l+1] = i_rs2[l];

    operand_bypass_mux #(
      .NUM_WB (NUM_LANES),
      .PREG_W (PREG_W),
      .XLEN   (XLEN)
    ) u_bypass_rs1 (
      .rs       (i_rs1[l]),
      .rf_data  (prf_rdata[2*l]),
      .wb_valid (wb_valid),
      .wb_rd    (wb_rd),
      .wb_data  (wb_data),
      .data     (src1)
    );

    operand_bypass_mux #(
      .NUM_WB (NUM_LANES),
      .PREG_W (PREG_W),
      .XLEN   (XLEN)
    ) u_bypass_rs2 (
      .rs       (i_rs2[l]),
      .rf_data  (prf_rdata[2*l+1]),
      .wb_valid (wb_valid),
      .wb_rd    (wb_rd),
      .wb_data  (wb_data),
      .data     (src2)
    );

    assign op_a = i_uses_rs1[l] ? src1 : '0;
    assign op_b = i_uses_imm[l] ? i_imm[l] : (i_uses_rs2[l] ? src2 : '0);

    // An op survives a recall only if its active-list entry is in the window.
    assign keep_new  = !if_recall || al_in_window(i_al_addr[l], back, new_front);
    assign keep_held = !if_recall || al_in_window(o_al_addr[l], back, new_front);

    // NOTE: state registers use non-blocking assignments so every slot
    // samples pre-edge values. All slot fields are plain flops (no RAM),
    // so they are all cleared by reset.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        o_valid[l]   <= 1'b0;
        o_op_a[l]    <= '0;
        o_op_b[l]    <= '0;
        o_rd[l]      <= '0;
        o_uses_rd[l] <= 1'b0;
        o_al_addr[l] <= '0;
        o_ctl[l]     <= '0;
      end else if (!stall_in) begin
        o_valid[l]   <= i_valid[l] && keep_new;
        o_op_a[l]    <= op_a;
        o_op_b[l]    <= op_b;
        o_rd[l]      <= i_rd[l];
        o_uses_rd[l] <= i_uses_rd[l];
        o_al_addr[l] <= i_al_addr[l];
        o_ctl[l]     <= i_ctl[l];
      end else if (!keep_held) begin
        // Recall overrides stall, but only the valid bit is touched.
        o_valid[l] <= 1'b0;
      end
    end
  end

  always_comb begin
    busy = 1'b0;
    for (int l = 0; l < NUM_LANES; l++) begin
      busy = busy | o_valid[l];
    end
  end

endmodule

// File: tb/tb_arith_operand_fetch.sv
module tb_arith_operand_fetch;
  import riscv_pkg::*;

  localparam int NL = 2;
  localparam int PW = 6;
  localparam int XL = 32;
  localparam int CW = 64;
  localparam int AW = AL_W;

  logic          clk, reset, stall_in, if_recall;
  logic          i_valid [NL], i_uses_rs1 [NL], i_uses_rs2 [NL], i_uses_imm [NL], i_uses_rd [NL];
  logic [PW-1:0] i_rs1 [NL], i_rs2 [NL], i_rd [NL];
  logic [XL-1:0] i_imm [NL];
  logic [AW-1:0] i_al_addr [NL];
  logic [CW-1:0] i_ctl [NL];
  logic [PW-1:0] prf_raddr [2*NL];
  logic [XL-1:0] prf_rdata [2*NL];
  logic          wb_valid [NL];
  logic [PW-1:0] wb_rd [NL];
  logic [XL-1:0] wb_data [NL];
  logic [AW-1:0] new_front, back;
  logic          o_valid [NL], o_uses_rd [NL];
  logic [XL-1:0] o_op_a [NL], o_op_b [NL];
  logic [PW-1:0] o_rd [NL];
  logic [AW-1:0] o_al_addr [NL];
  logic [CW-1:0] o_ctl [NL];
  logic          busy;

  logic [XL-1:0] prf [64];

  typedef struct {
    logic          v;
    logic [XL-1:0] a;
    logic [XL-1:0] b;
    logic [PW-1:0] rd;
    logic          urd;
    logic [AW-1:0] al;
    logic [CW-1:0] ctl;
  } slot_t;

  slot_t mdl [NL];
  slot_t nxt [NL];
  int    checks = 0;
  int    errors = 0;

  arith_operand_fetch dut (
    .clk(clk), .reset(reset), .stall_in(stall_in),
    .i_valid(i_valid), .i_rs1(i_rs1), .i_rs2(i_rs2), .i_rd(i_rd),
    .i_uses_rs1(i_uses_rs1), .i_uses_rs2(i_uses_rs2), .i_uses_imm(i_uses_imm),
    .i_uses_rd(i_uses_rd), .i_imm(i_imm), .i_al_addr(i_al_addr), .i_ctl(i_ctl),
    .prf_raddr(prf_raddr), .prf_rdata(prf_rdata),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .if_recall(if_recall), .new_front(new_front), .back(back),
    .o_valid(o_valid), .o_op_a(o_op_a), .o_op_b(o_op_b), .o_rd(o_rd),
    .o_uses_rd(o_uses_rd), .o_al_addr(o_al_addr), .o_ctl(o_ctl), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file behaves as a combinational read port.
  always_comb begin
    for (int i = 0; i < 2*NL; i++) prf_rdata[i] = prf[prf_raddr[i]];
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // ---- reference model -------------------------------------------------
  function automatic logic [XL-1:0] resolve(input logic [PW-1:0] rs);
    for (int k = 0; k < NL; k++)
      if (wb_valid[k] && wb_rd[k] == rs) return wb_data[k];
    return prf[rs];
  endfunction

  function automatic bit in_win(input int a);
    int span = (int'(new_front) - int'(back) + AL_SIZE) % AL_SIZE;
    return ((a - int'(back) + AL_SIZE) % AL_SIZE) < span;
  endfunction

  task automatic model_next();
    for (int l = 0; l < NL; l++) begin
      if (!stall_in) begin
        nxt[l].v   = i_valid[l] && !(if_recall && !in_win(int'(i_al_addr[l])));
        nxt[l].a   = i_uses_rs1[l] ? resolve(i_rs1[l]) : '0;
        nxt[l].b   = i_uses_imm[l] ? i_imm[l] : (i_uses_rs2[l] ? resolve(i_rs2[l]) : '0);
        nxt[l].rd  = i_rd[l];
        nxt[l].urd = i_uses_rd[l];
        nxt[l].al  = i_al_addr[l];
        nxt[l].ctl = i_ctl[l];
      end else begin
        nxt[l] = mdl[l];
        if (if_recall && !in_win(int'(mdl[l].al))) nxt[l].v = 1'b0;
      end
    end
  endtask

  task automatic model_reset();
    for (int l = 0; l < NL; l++) mdl[l] = '{1'b0, '0, '0, '0, 1'b0, '0, '0};
  endtask

  // ---- compare process -------------------------------------------------
  always @(negedge clk) begin
    for (int l = 0; l < NL; l++) begin
      check($sformatf("cmp lane%0d valid", l), 64'(o_valid[l]), 64'(mdl[l].v));
      if (mdl[l].v || reset) begin
        check($sformatf("cmp lane%0d op_a", l), 64'(o_op_a[l]), 64'(mdl[l].a));
        check($sformatf("cmp lane%0d op_b", l), 64'(o_op_b[l]), 64'(mdl[l].b));
        check($sformatf("cmp lane%0d rd", l), 64'(o_rd[l]), 64'(mdl[l].rd));
        check($sformatf("cmp lane%0d uses_rd", l), 64'(o_uses_rd[l]), 64'(mdl[l].urd));
        check($sformatf("cmp lane%0d al", l), 64'(o_al_addr[l]), 64'(mdl[l].al));
        check($sformatf("cmp lane%0d ctl", l), o_ctl[l], mdl[l].ctl);
      end
    end
    check("cmp busy", 64'(busy), 64'(mdl[0].v | mdl[1].v));
  end

  // ---- stimulus helpers ------------------------------------------------
  task automatic clear_inputs();
    stall_in = 0; if_recall = 0; new_front = '0; back = '0;
    for (int l = 0; l < NL; l++) begin
      i_valid[l] = 0; i_uses_rs1[l] = 0; i_uses_rs2[l] = 0; i_uses_imm[l] = 0; i_uses_rd[l] = 0;
      i_rs1[l] = '0; i_rs2[l] = '0; i_rd[l] = '0; i_imm[l] = '0; i_al_addr[l] = '0; i_ctl[l] = '0;
      wb_valid[l] = 0; wb_rd[l] = '0; wb_data[l] = '0;
    end
  endtask

  // Inputs are driven after a falling edge; one step is one rising edge.
  task automatic step();
    #1;
    for (int l = 0; l < NL; l++) begin
      check($sformatf("prf_raddr rs1 lane%0d", l), 64'(prf_raddr[2*l]), 64'(i_rs1[l]));
      check($sformatf("prf_raddr rs2 lane%0d", l), 64'(prf_raddr[2*l+1]), 64'(i_rs2[l]));
    end
    model_next();
    @(posedge clk);
    if (!reset) mdl = nxt;
    @(negedge clk);
  endtask

  task automatic randomize_inputs();
    stall_in  = ($urandom % 10) < 3;
    if_recall = ($urandom % 10) < 2;
    back      = AW'($urandom % AL_SIZE);
    new_front = AW'($urandom % AL_SIZE);
    prf[$urandom % 16] = $urandom;
    for (int l = 0; l < NL; l++) begin
      i_valid[l]    = ($urandom % 4) != 0;
      i_uses_rs1[l] = $urandom % 2;
      i_uses_rs2[l] = $urandom % 2;
      i_uses_imm[l] = ($urandom % 3) == 0;
      i_uses_rd[l]  = $urandom % 2;
      i_rs1[l]      = PW'(($urandom % 4 == 0) ? $urandom % 64 : $urandom % 16);
      i_rs2[l]      = PW'(($urandom % 4 == 0) ? $urandom % 64 : $urandom % 16);
      i_rd[l]       = PW'($urandom % 64);
      i_imm[l]      = $urandom;
      i_al_addr[l]  = AW'($urandom % AL_SIZE);
      i_ctl[l]      = {$urandom, $urandom};
      wb_valid[l]   = $urandom % 2;
      wb_rd[l]      = PW'($urandom % 16);
      wb_data[l]    = $urandom;
    end
  endtask

  // ---- test sequence ---------------------------------------------------
  initial begin
    reset = 1'b1;
    clear_inputs();
    model_reset();
    for (int i = 0; i < 64; i++) prf[i] = $urandom;
    repeat (2) @(negedge clk);

    check("reset valid0", 64'(o_valid[0]), 64'd0);
    check("reset valid1", 64'(o_valid[1]), 64'd0);
    check("reset op_a0", 64'(o_op_a[0]), 64'd0);
    check("reset op_b1", 64'(o_op_b[1]), 64'd0);
    check("reset ctl1", o_ctl[1], 64'd0);
    check("reset busy", 64'(busy), 64'd0);
    reset = 1'b0;

    // Plain PRF read.
    clear_inputs();
    i_valid[0] = 1; i_uses_rs1[0] = 1; i_uses_rs2[0] = 1; i_rs1[0] = 5; i_rs2[0] = 9;
    prf[5] = 32'h11; prf[9] = 32'h22;
    step();
    check("prf valid0", 64'(o_valid[0]), 64'd1);
    check("prf op_a0", 64'(o_op_a[0]), 64'h11);
    check("prf op_b0", 64'(o_op_b[0]), 64'h22);

    // Two writeback ports hit the same register: port 0 wins.
    clear_inputs();
    i_valid[0] = 1; i_uses_rs1[0] = 1; i_rs1[0] = 5;
    wb_valid[0] = 1; wb_valid[1] = 1; wb_rd[0] = 5; wb_rd[1] = 5;
    wb_data[0] = 32'hAA; wb_data[1] = 32'hBB;
    step();
    check("bypass op_a0", 64'(o_op_a[0]), 64'hAA);

    // Immediate replaces rs2; unused rs1 reads as zero.
    clear_inputs();
    i_valid[0] = 1; i_uses_imm[0] = 1; i_uses_rs2[0] = 1; i_rs1[0] = 5; i_rs2[0] = 9;
    i_imm[0] = 32'hFFFF_FFF0;
    step();
    check("imm op_a0", 64'(o_op_a[0]), 64'h0);
    check("imm op_b0", 64'(o_op_b[0]), 64'hFFFF_FFF0);

    // Stall holds the slot even as inputs and PRF contents change.
    clear_inputs();
    i_valid[0] = 1; i_uses_rs1[0] = 1; i_rs1[0] = 3; prf[3] = 32'h33;
    step();
    check("stall load op_a0", 64'(o_op_a[0]), 64'h33);
    for (int c = 0; c < 3; c++) begin
      stall_in = 1; i_rs1[0] = 7; i_valid[0] = c[0];
      prf[3] = $urandom; prf[7] = $urandom;
      step();
      check($sformatf("stall hold op_a0 c%0d", c), 64'(o_op_a[0]), 64'h33);
      check($sformatf("stall hold valid0 c%0d", c), 64'(o_valid[0]), 64'd1);
    end

    // Wrapping window [30,2): entry 31 survives, entry 4 is flushed.
    clear_inputs();
    i_valid[0] = 1; i_valid[1] = 1; i_al_addr[0] = 31; i_al_addr[1] = 4;
    step();
    check("recall pre valid1", 64'(o_valid[1]), 64'd1);
    stall_in = 1; if_recall = 1; back = 30; new_front = 2;
    step();
    check("recall al31 kept", 64'(o_valid[0]), 64'd1);
    check("recall al4 flushed", 64'(o_valid[1]), 64'd0);

    // Empty window flushes held and incoming ops alike.
    clear_inputs();
    i_valid[0] = 1; i_valid[1] = 1; i_al_addr[0] = 7; i_al_addr[1] = 8;
    step();
    if_recall = 1; back = 12; new_front = 12; i_al_addr[0] = 12; i_al_addr[1] = 13;
    step();
    check("empty win valid0", 64'(o_valid[0]), 64'd0);
    check("empty win valid1", 64'(o_valid[1]), 64'd0);
    check("empty win busy", 64'(busy), 64'd0);

    // Asynchronous reset clears slots before the next clock edge.
    clear_inputs();
    i_valid[0] = 1; i_valid[1] = 1;
    step();
    check("pre-reset busy", 64'(busy), 64'd1);
    #2 reset = 1'b1;
    model_reset();
    #1;
    check("async reset valid0", 64'(o_valid[0]), 64'd0);
    check("async reset valid1", 64'(o_valid[1]), 64'd0);
    check("async reset busy", 64'(busy), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    // Randomized traffic against the model.
    for (int c = 0; c < 400; c++) begin
      randomize_inputs();
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
